// File: rtl/uart_frame_checker.sv
// uart_frame_checker: oversampled UART receiver that compares each received payload
// with the head of a queue of expected values and keeps saturating pass/fail counts.
module uart_frame_checker #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE   = 32,
  parameter int EXP_DEPTH  = 4,
  parameter int CNT_WIDTH  = 16,
  parameter bit MSB_FIRST  = 1'b0
) (
  input  logic                  uart_clk,
  input  logic                  rst,
  input  logic                  rx_in,
  input  logic                  par_en,
  input  logic                  par_typ,
  input  logic [DATA_WIDTH-1:0] exp_data,
  input  logic                  exp_valid,
  output logic                  exp_ready,
  output logic                  frame_done,
  output logic [DATA_WIDTH-1:0] frame_data,
  output logic                  match,
  output logic                  par_err,
  output logic                  stp_err,
  output logic                  no_exp,
  output logic [CNT_WIDTH-1:0]  pass_cnt,
  output logic [CNT_WIDTH-1:0]  fail_cnt,
  output logic                  busy
);

  localparam int PW = $clog2(PRESCALE);
  localparam int BW = $clog2(DATA_WIDTH);
  localparam int AW = (EXP_DEPTH > 1) ? $clog2(EXP_DEPTH) : 1;
  localparam int CW = $clog2(EXP_DEPTH + 1);

  localparam logic [PW-1:0]        SAMP_A   = PW'(PRESCALE / 2 - 1);
  localparam logic [PW-1:0]        SAMP_B   = PW'(PRESCALE / 2);
  localparam logic [PW-1:0]        SAMP_C   = PW'(PRESCALE / 2 + 1);
  localparam logic [PW-1:0]        BIT_LAST = PW'(PRESCALE - 1);
  localparam logic [BW-1:0]        IDX_LAST = BW'(DATA_WIDTH - 1);
  localparam logic [AW-1:0]        PTR_LAST = AW'(EXP_DEPTH - 1);
  localparam logic [CW-1:0]        DEPTH    = CW'(EXP_DEPTH);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} state_t;

  state_t                  state_q, state_d;
  logic                    sync1_q, sync1_d, sync2_q, sync2_d;
  logic [PW-1:0]           cnt_q, cnt_d;
  logic [BW-1:0]           idx_q, idx_d;
  logic                    samp_a_q, samp_a_d, samp_b_q, samp_b_d;
  logic [DATA_WIDTH-1:0]   shift_q, shift_d;
  logic                    par_en_q, par_en_d, par_typ_q, par_typ_d;
  logic                    perr_q, perr_d;
  logic                    frame_done_q, frame_done_d;
  logic [DATA_WIDTH-1:0]   frame_data_q, frame_data_d;
  logic                    match_q, match_d;
  logic                    par_err_q, par_err_d;
  logic                    stp_err_q, stp_err_d;
  logic                    no_exp_q, no_exp_d;
  logic [CNT_WIDTH-1:0]    pass_cnt_q, pass_cnt_d, fail_cnt_q, fail_cnt_d;
  logic [DATA_WIDTH-1:0]   mem_q [EXP_DEPTH];
  logic [DATA_WIDTH-1:0]   mem_d [EXP_DEPTH];
  logic [AW-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]           count_q, count_d;

  logic                    line, maj, at_a, at_b, at_c, at_end, last_bit, frame_fin;
  logic                    push, pop, q_empty;
  logic [DATA_WIDTH-1:0]   head;

  assign line      = sync2_q;
  assign maj       = (samp_a_q & samp_b_q) | (samp_a_q & line) | (samp_b_q & line);
  assign at_a      = (cnt_q == SAMP_A);
  assign at_b      = (cnt_q == SAMP_B);
  assign at_c      = (cnt_q == SAMP_C);
  assign at_end    = (cnt_q == BIT_LAST);
  assign last_bit  = (idx_q == IDX_LAST);
  assign frame_fin = (state_q == STOP) && at_c;

  assign exp_ready  = (count_q < DEPTH);
  assign busy       = (state_q != IDLE);
  assign frame_done = frame_done_q;
  assign frame_data = frame_data_q;
  assign match      = match_q;
  assign par_err    = par_err_q;
  assign stp_err    = stp_err_q;
  assign no_exp     = no_exp_q;
  assign pass_cnt   = pass_cnt_q;
  assign fail_cnt   = fail_cnt_q;

  always_ff @(posedge uart_clk) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (!line) state_d = START;
      START: begin
        if (at_c && maj)  state_d = IDLE;
        else if (at_end)  state_d = DATA;
      end
      DATA:      if (at_end && last_bit) state_d = par_en_q ? PARITY : STOP;
      PARITY:    if (at_end) state_d = STOP;
      STOP:      if (at_c) state_d = maj ? IDLE : WAIT_HIGH;
      WAIT_HIGH: if (line) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Frame datapath, expected-value queue and completion bookkeeping.
  always_comb begin
    sync1_d   = rx_in;
    sync2_d   = sync1_q;
    cnt_d     = (state_q == IDLE || state_q == WAIT_HIGH || at_end) ? '0 : cnt_q + 1'b1;
    idx_d     = idx_q;
    samp_a_d  = at_a ? line : samp_a_q;
    samp_b_d  = at_b ? line : samp_b_q;
    shift_d   = shift_q;
    par_en_d  = par_en_q;
    par_typ_d = par_typ_q;
    perr_d    = perr_q;

    case (state_q)
      START: begin
        if (at_c && !maj) begin
          par_en_d  = par_en;
          par_typ_d = par_typ;
          perr_d    = 1'b0;
          idx_d     = '0;
        end
      end
      DATA: begin
        if (at_c) begin
          shift_d = MSB_FIRST ? {shift_q[DATA_WIDTH-2:0], maj} : {maj, shift_q[DATA_WIDTH-1:1]};
        end
        if (at_end) idx_d = idx_q + 1'b1;
      end
      PARITY: if (at_c) perr_d = (maj != (^shift_q ^ par_typ_q));
      default: ;
    endcase

    // An empty queue being pushed this cycle still supplies the comparison value.
    push     = exp_valid && exp_ready;
    q_empty  = (count_q == '0);
    pop      = frame_fin && (!q_empty || push);
    head     = q_empty ? exp_data : mem_q[rd_ptr_q];
    mem_d    = mem_q;
    if (push) mem_d[wr_ptr_q] = exp_data;
    wr_ptr_d = push ? ((wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1) : wr_ptr_q;
    rd_ptr_d = pop  ? ((rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1) : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (!push && pop) count_d = count_q - 1'b1;

    frame_done_d = frame_fin;
    frame_data_d = frame_data_q;
    match_d      = match_q;
    par_err_d    = par_err_q;
    stp_err_d    = stp_err_q;
    no_exp_d     = no_exp_q;
    pass_cnt_d   = pass_cnt_q;
    fail_cnt_d   = fail_cnt_q;
    if (frame_fin) begin
      frame_data_d = shift_q;
      par_err_d    = perr_q;
      stp_err_d    = !maj;
      no_exp_d     = !pop;
      match_d      = pop && !perr_q && maj && (shift_q == head);
      if (match_d) begin
        if (pass_cnt_q != CNT_MAX) pass_cnt_d = pass_cnt_q + 1'b1;
      end else begin
        if (fail_cnt_q != CNT_MAX) fail_cnt_d = fail_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge uart_clk) begin
    if (!rst) begin
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      cnt_q        <= '0;
      idx_q        <= '0;
      samp_a_q     <= 1'b1;
      samp_b_q     <= 1'b1;
      shift_q      <= '0;
      par_en_q     <= 1'b0;
      par_typ_q    <= 1'b0;
      perr_q       <= 1'b0;
      frame_done_q <= 1'b0;
      frame_data_q <= '0;
      match_q      <= 1'b0;
      par_err_q    <= 1'b0;
      stp_err_q    <= 1'b0;
      no_exp_q     <= 1'b0;
      pass_cnt_q   <= '0;
      fail_cnt_q   <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      samp_a_q     <= samp_a_d;
      samp_b_q     <= samp_b_d;
      shift_q      <= shift_d;
      par_en_q     <= par_en_d;
      par_typ_q    <= par_typ_d;
      perr_q       <= perr_d;
      frame_done_q <= frame_done_d;
      frame_data_q <= frame_data_d;
      match_q      <= match_d;
      par_err_q    <= par_err_d;
      stp_err_q    <= stp_err_d;
      no_exp_q     <= no_exp_d;
      pass_cnt_q   <= pass_cnt_d;
      fail_cnt_q   <= fail_cnt_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
    end
  end

  always_ff @(posedge uart_clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_uart_frame_checker.sv
// Testbench for uart_frame_checker: an LSB-first instance and an MSB-first instance
// receive serial frames; every frame_done is scored against a reference model.
module tb_uart_frame_checker;

  localparam int P = 32;

  logic        uart_clk = 1'b0;
  logic        rst;
  logic        rx_a, rx_b, par_en, par_typ, exp_valid_a, exp_valid_b;
  logic [7:0]  exp_data;

  logic        exp_ready_a, frame_done_a, match_a, par_err_a, stp_err_a, no_exp_a, busy_a;
  logic [7:0]  frame_data_a;
  logic [15:0] pass_cnt_a, fail_cnt_a;
  logic        exp_ready_b, frame_done_b, match_b, par_err_b, stp_err_b, no_exp_b, busy_b;
  logic [7:0]  frame_data_b;
  logic [15:0] pass_cnt_b, fail_cnt_b;

  typedef struct {
    logic [7:0]  data;
    logic        match;
    logic        perr;
    logic        serr;
    logic        noexp;
    logic [15:0] pcnt;
    logic [15:0] fcnt;
  } exp_t;

  logic [7:0]  mq_a[$];
  logic [7:0]  mq_b[$];
  exp_t        sb_a[$];
  exp_t        sb_b[$];
  exp_t        ea, eb;
  logic [15:0] mpass [2];
  logic [15:0] mfail [2];
  int          errCount = 0;
  int          checkCount = 0;

  always #5 uart_clk = ~uart_clk;

  uart_frame_checker #(.DATA_WIDTH(8), .PRESCALE(P), .EXP_DEPTH(4), .CNT_WIDTH(16), .MSB_FIRST(1'b0)) dut_a (
    .uart_clk(uart_clk), .rst(rst), .rx_in(rx_a), .par_en(par_en), .par_typ(par_typ),
    .exp_data(exp_data), .exp_valid(exp_valid_a), .exp_ready(exp_ready_a),
    .frame_done(frame_done_a), .frame_data(frame_data_a), .match(match_a),
    .par_err(par_err_a), .stp_err(stp_err_a), .no_exp(no_exp_a),
    .pass_cnt(pass_cnt_a), .fail_cnt(fail_cnt_a), .busy(busy_a)
  );

  uart_frame_checker #(.DATA_WIDTH(8), .PRESCALE(P), .EXP_DEPTH(4), .CNT_WIDTH(16), .MSB_FIRST(1'b1)) dut_b (
    .uart_clk(uart_clk), .rst(rst), .rx_in(rx_b), .par_en(par_en), .par_typ(par_typ),
    .exp_data(exp_data), .exp_valid(exp_valid_b), .exp_ready(exp_ready_b),
    .frame_done(frame_done_b), .frame_data(frame_data_b), .match(match_b),
    .par_err(par_err_b), .stp_err(stp_err_b), .no_exp(no_exp_b),
    .pass_cnt(pass_cnt_b), .fail_cnt(fail_cnt_b), .busy(busy_b)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checkCount++;
    if (obs !== expv) begin
      errCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  function automatic logic goodPar(input logic [7:0] d);
    return ^d ^ par_typ;
  endfunction

  task automatic pushExp(input bit which, input logic [7:0] d);
    @(negedge uart_clk);
    exp_data = d;
    if (which) begin
      exp_valid_b = 1'b1;
      if (mq_b.size() < 4) mq_b.push_back(d);
    end else begin
      exp_valid_a = 1'b1;
      if (mq_a.size() < 4) mq_a.push_back(d);
    end
    @(negedge uart_clk);
    exp_valid_a = 1'b0;
    exp_valid_b = 1'b0;
  endtask

  task automatic driveLine(input bit which, input logic v, input int n);
    if (which) rx_b = v;
    else rx_a = v;
    repeat (n) @(negedge uart_clk);
  endtask

  // Predict the frame outcome, queue the expectation, then serialise the frame.
  task automatic applyStimulus(input bit which, input logic [7:0] d, input logic pbit, input int stop_low);
    exp_t       e;
    logic [7:0] head = 8'h00;
    logic       have;
    have = which ? (mq_b.size() > 0) : (mq_a.size() > 0);
    if (have) head = which ? mq_b.pop_front() : mq_a.pop_front();
    e.data  = d;
    e.perr  = par_en && (pbit != (^d ^ par_typ));
    e.serr  = (stop_low > 0);
    e.noexp = !have;
    e.match = have && !e.perr && !e.serr && (d == head);
    if (e.match) begin
      if (mpass[which] != 16'hFFFF) mpass[which] = mpass[which] + 16'd1;
    end else begin
      if (mfail[which] != 16'hFFFF) mfail[which] = mfail[which] + 16'd1;
    end
    e.pcnt = mpass[which];
    e.fcnt = mfail[which];
    if (which) sb_b.push_back(e);
    else sb_a.push_back(e);

    driveLine(which, 1'b0, P);
    for (int i = 0; i < 8; i++) driveLine(which, which ? d[7-i] : d[i], P);
    if (par_en) driveLine(which, pbit, P);
    if (stop_low > 0) begin
      driveLine(which, 1'b0, stop_low - 8);
      checkOutput("busy_in_wait_high", 32'(which ? busy_b : busy_a), 32'd1);
      driveLine(which, 1'b0, 8);
    end
    driveLine(which, 1'b1, P);
  endtask

  task automatic waitDrain(input int budget);
    int n = 0;
    while ((sb_a.size() + sb_b.size()) != 0 && n < budget) begin
      @(negedge uart_clk);
      n++;
    end
    checkOutput("scoreboard_drained", 32'(sb_a.size() + sb_b.size()), 32'd0);
  endtask

  always @(negedge uart_clk) begin
    if (frame_done_a === 1'b1) begin
      if (sb_a.size() == 0) begin
        checkOutput("a_unexpected_frame", 32'(frame_done_a), 32'd0);
      end else begin
        ea = sb_a.pop_front();
        checkOutput("a_frame_data", 32'(frame_data_a), 32'(ea.data));
        checkOutput("a_match", 32'(match_a), 32'(ea.match));
        checkOutput("a_par_err", 32'(par_err_a), 32'(ea.perr));
        checkOutput("a_stp_err", 32'(stp_err_a), 32'(ea.serr));
        checkOutput("a_no_exp", 32'(no_exp_a), 32'(ea.noexp));
        checkOutput("a_pass_cnt", 32'(pass_cnt_a), 32'(ea.pcnt));
        checkOutput("a_fail_cnt", 32'(fail_cnt_a), 32'(ea.fcnt));
      end
    end
  end

  always @(negedge uart_clk) begin
    if (frame_done_b === 1'b1) begin
      if (sb_b.size() == 0) begin
        checkOutput("b_unexpected_frame", 32'(frame_done_b), 32'd0);
      end else begin
        eb = sb_b.pop_front();
        checkOutput("b_frame_data", 32'(frame_data_b), 32'(eb.data));
        checkOutput("b_match", 32'(match_b), 32'(eb.match));
        checkOutput("b_par_err", 32'(par_err_b), 32'(eb.perr));
        checkOutput("b_stp_err", 32'(stp_err_b), 32'(eb.serr));
        checkOutput("b_no_exp", 32'(no_exp_b), 32'(eb.noexp));
        checkOutput("b_pass_cnt", 32'(pass_cnt_b), 32'(eb.pcnt));
        checkOutput("b_fail_cnt", 32'(fail_cnt_b), 32'(eb.fcnt));
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b0; rx_a = 1'b1; rx_b = 1'b1; par_en = 1'b1; par_typ = 1'b0;
    exp_valid_a = 1'b0; exp_valid_b = 1'b0; exp_data = 8'h00;
    mpass[0] = 16'd0; mpass[1] = 16'd0; mfail[0] = 16'd0; mfail[1] = 16'd0;
    repeat (3) @(negedge uart_clk);
    checkOutput("reset_exp_ready", 32'(exp_ready_a), 32'd1);
    checkOutput("reset_busy", 32'(busy_a), 32'd0);
    checkOutput("reset_frame_done", 32'(frame_done_a), 32'd0);
    checkOutput("reset_pass_cnt", 32'(pass_cnt_a), 32'd0);
    checkOutput("reset_fail_cnt", 32'(fail_cnt_a), 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge uart_clk);

    $display("[TB] good frame with expected value");
    pushExp(0, 8'h26);
    applyStimulus(0, 8'h26, goodPar(8'h26), 0);
    waitDrain(200);
    checkOutput("case1_exp_ready", 32'(exp_ready_a), 32'd1);

    $display("[TB] parity error then back-to-back good frame");
    pushExp(0, 8'h31);
    pushExp(0, 8'h30);
    applyStimulus(0, 8'h31, !goodPar(8'h31), 0);
    applyStimulus(0, 8'h30, goodPar(8'h30), 0);
    waitDrain(200);

    $display("[TB] stop bit held low, then recovery");
    pushExp(0, 8'hAA);
    applyStimulus(0, 8'hAA, goodPar(8'hAA), 64);
    driveLine(0, 1'b1, P);
    checkOutput("case3_busy_after_high", 32'(busy_a), 32'd0);
    pushExp(0, 8'hBB);
    applyStimulus(0, 8'hBB, goodPar(8'hBB), 0);
    waitDrain(200);

    $display("[TB] short glitch on the line");
    driveLine(0, 1'b0, 8);
    driveLine(0, 1'b1, 3 * P);
    checkOutput("case4_busy", 32'(busy_a), 32'd0);
    checkOutput("case4_pass_cnt", 32'(pass_cnt_a), 32'(mpass[0]));
    checkOutput("case4_fail_cnt", 32'(fail_cnt_a), 32'(mfail[0]));

    $display("[TB] frame with empty queue, then odd parity");
    applyStimulus(0, 8'h05, goodPar(8'h05), 0);
    par_typ = 1'b1;
    pushExp(0, 8'h26);
    applyStimulus(0, 8'h26, goodPar(8'h26), 0);
    par_typ = 1'b0;
    waitDrain(200);

    $display("[TB] queue full, ignored push, mid-frame reset");
    pushExp(0, 8'h11);
    pushExp(0, 8'h22);
    pushExp(0, 8'h33);
    checkOutput("case6_ready_three", 32'(exp_ready_a), 32'd1);
    pushExp(0, 8'h44);
    checkOutput("case6_ready_full", 32'(exp_ready_a), 32'd0);
    pushExp(0, 8'h55);
    checkOutput("case6_ready_still_full", 32'(exp_ready_a), 32'd0);
    applyStimulus(0, 8'h11, goodPar(8'h11), 0);
    applyStimulus(0, 8'h22, goodPar(8'h22), 0);
    applyStimulus(0, 8'h33, goodPar(8'h33), 0);
    applyStimulus(0, 8'h44, goodPar(8'h44), 0);
    applyStimulus(0, 8'h55, goodPar(8'h55), 0);
    waitDrain(200);

    pushExp(0, 8'h66);
    pushExp(0, 8'h77);
    driveLine(0, 1'b0, 3 * P);
    checkOutput("case6_busy_mid_frame", 32'(busy_a), 32'd1);
    rst = 1'b0;
    mq_a.delete();
    mq_b.delete();
    mpass[0] = 16'd0; mpass[1] = 16'd0; mfail[0] = 16'd0; mfail[1] = 16'd0;
    repeat (2) @(negedge uart_clk);
    rx_a = 1'b1;
    rst = 1'b1;
    @(negedge uart_clk);
    checkOutput("rst_pass_cnt", 32'(pass_cnt_a), 32'd0);
    checkOutput("rst_fail_cnt", 32'(fail_cnt_a), 32'd0);
    checkOutput("rst_exp_ready", 32'(exp_ready_a), 32'd1);
    checkOutput("rst_busy", 32'(busy_a), 32'd0);
    checkOutput("rst_frame_data", 32'(frame_data_a), 32'd0);
    checkOutput("rst_match", 32'(match_a), 32'd0);
    driveLine(0, 1'b1, 4 * P);
    applyStimulus(0, 8'h07, goodPar(8'h07), 0);
    waitDrain(200);

    $display("[TB] MSB-first instance without parity");
    par_en = 1'b0;
    pushExp(1, 8'h26);
    applyStimulus(1, 8'h26, 1'b0, 0);
    waitDrain(200);
    checkOutput("b_exp_ready_after", 32'(exp_ready_b), 32'd1);

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule

// File: doc/uart_frame_checker.md
Name: uart_frame_checker

Overview:
Synthesizable self-checking UART frame monitor for the CREM command/response path. It watches a serial line (e.g. tx_out), oversamples it and deserialises frames of configurable width, parity mode and bit order. Each received frame is compared against the head of an internal queue of expected values, and the block keeps saturating pass/fail counters. It replaces the software-only capture/check flow, so on-chip and FPGA regression runs can check response bytes without a host.

Parameters:
DATA_WIDTH, 8, payload bits per frame (5..9)
PRESCALE, 32, uart_clk cycles per bit; even, >= 8
EXP_DEPTH, 4, expected-value queue entries; power of 2
CNT_WIDTH, 16, width of pass/fail counters
MSB_FIRST, 0, 0 = payload LSB first on the line; 1 = MSB first

Ports:
uart_clk  in  1  sole clock; all logic on rising edge
rst  in  1  synchronous active-low reset
rx_in  in  1  monitored serial line, idle high, asynchronous to uart_clk
par_en  in  1  1 = a parity bit follows the payload
par_typ  in  1  0 = even parity, 1 = odd parity
exp_data  in  DATA_WIDTH  expected payload to enqueue
exp_valid  in  1  enqueue request
exp_ready  out  1  queue not full
frame_done  out  1  1-cycle pulse when a frame completes
frame_data  out  DATA_WIDTH  last received payload
match  out  1  last frame passed (valid when frame_done is high, held afterwards)
par_err  out  1  last frame had a parity mismatch
stp_err  out  1  last frame had stop bit sampled 0
no_exp  out  1  last frame arrived with the queue empty
pass_cnt  out  CNT_WIDTH  frames passed, saturating
fail_cnt  out  CNT_WIDTH  frames failed, saturating
busy  out  1  FSM not in IDLE

Behaviour:
- Reset (rst = 0 at a uart_clk edge):
  - All outputs go to 0, except exp_ready = 1.
  - The queue empties, the FSM returns to IDLE and the synchroniser flops load 1.
  - Reset mid-frame discards the partial frame; no frame_done is produced.
- rx_in passes through a 2-flop synchroniser, reset value 1. Every reference to "line" below means the synchronised value.
- Bit counter runs 0..PRESCALE-1 within each bit. The three samples are taken at PRESCALE/2-1, PRESCALE/2 and PRESCALE/2+1, and the bit value is the 2-of-3 majority.
- FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
  - IDLE: line = 0 -> START, bit counter = 0.
  - START: at sample point, majority 1 -> IDLE (glitch, nothing counted); otherwise -> DATA at counter PRESCALE-1.
  - DATA: shifts DATA_WIDTH bits, placed per MSB_FIRST. After the last bit, go to PARITY if par_en = 1, else to STOP.
  - PARITY: expected parity bit = XOR(payload) XOR par_typ. A mismatch sets the internal par_err flag.
  - STOP: at the PRESCALE/2+1 sample the frame completes. Stop majority 1 -> IDLE (no wait for bit end, so back-to-back frames are accepted). Stop majority 0 -> stp_err and go to WAIT_HIGH.
  - WAIT_HIGH: stay until line = 1, then -> IDLE.
- par_en and par_typ are sampled at the start-bit decision and held for the whole frame.
- Completion, registered 1 cycle after the stop sample:
  - frame_done = 1 for 1 cycle.
  - frame_data, par_err, stp_err and no_exp update.
  - If the queue is non-empty, pop the head and set match = !par_err & !stp_err & (payload == head).
  - If the queue is empty, set no_exp = 1 and match = 0.
  - match = 1 -> pass_cnt + 1; otherwise fail_cnt + 1. Both counters hold at all-ones.
- Queue:
  - Synchronous FIFO; pointers wrap modulo EXP_DEPTH, with a separate occupancy count.
  - exp_ready = (count < EXP_DEPTH). A push while full is ignored.
  - A push and a pop in the same cycle are both performed and count is unchanged. If the queue is full that cycle, exp_ready = 0, so only the pop takes effect.
  - A push into an empty queue is visible to a frame completing in the same cycle: the comparison uses exp_data bypassed from the input, and that entry is consumed.
- Latency, start edge on the pin to frame_done: 2 synchroniser cycles + (1 + DATA_WIDTH + par_en) × PRESCALE + PRESCALE/2 + 2 cycles.

Test Plan:
Defaults: PRESCALE = 32, DATA_WIDTH = 8, MSB_FIRST = 0, par_en = 1, par_typ = 0.
1. Reset, push 0x26, send 0x26 with parity 1 -> one frame_done pulse; frame_data = 0x26, match = 1, pass_cnt = 1, queue empty.
2. Push 0x31, send 0x31 with parity 0 -> par_err = 1, match = 0, fail_cnt = 1. Then push 0x30, send 0x30 with parity 0 back-to-back -> match = 1, pass_cnt = 2.
3. Push 0xAA, send 0xAA with the stop bit held 0 for 64 cycles -> stp_err = 1, fail_cnt + 1, busy stays high until the line returns high. The next frame 0xBB is then received correctly.
4. Drive rx_in low for 8 cycles then high -> no frame_done, busy returns to 0, counters unchanged.
5. Queue empty, send 0x05 with parity 0 -> no_exp = 1, match = 0, fail_cnt + 1.
6. Push 4 values -> exp_ready = 0; a 5th push is ignored. Assert rst mid-frame -> all counters 0, queue empty, exp_ready = 1, no frame_done afterwards. Repeat case 1 with MSB_FIRST = 1 and par_en = 0 -> match = 1.
